// File: rtl/bus_control_unit.sv
// Time-step sequencer for the mv/mvi/add/sub datapath.
// Chooses the bus driver each cycle and strobes the register loads.
module bus_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] DIN,
  output logic [9:0]  Select,
  output logic [7:0]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        IRin,
  output logic        AddSub,
  output logic        Done
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [9:0] SEL_DIN = 10'h200;
  localparam logic [9:0] SEL_G   = 10'h100;

  logic [1:0] state_q, state_d;
  logic [8:0] ir_q, ir_d;

  logic [2:0] opc, rx, ry;
  logic       op_mv, op_mvi, op_alu, op_undef;

  assign opc = ir_q[8:6];
  assign rx  = ir_q[5:3];
  assign ry  = ir_q[2:0];

  assign op_mv    = (opc == 3'b000);
  assign op_mvi   = (opc == 3'b001);
  assign op_alu   = (opc[2:1] == 2'b01);
  assign op_undef = opc[2];

  // Register k drives the bus through Select[7-k]
  function automatic logic [9:0] sel_reg(
    input logic [2:0] k
  );
    return 10'h080 >> k;
  endfunction

  function automatic logic [7:0] rin_reg(
    input logic [2:0] k
  );
    return 8'h01 << k;
  endfunction

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    Select  = '0;
    Rin     = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    IRin    = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      T0: begin
        if (Run) begin
          IRin    = 1'b1;
          ir_d    = DIN[8:0];
          state_d = T1;
        end
      end
      T1: begin
        unique case (1'b1)
          op_mv: begin
            Select  = sel_reg(ry);
            Rin     = rin_reg(rx);
            Done    = 1'b1;
            state_d = T0;
          end
          op_mvi: begin
            Select  = SEL_DIN;
            Rin     = rin_reg(rx);
            Done    = 1'b1;
            state_d = T0;
          end
          op_alu: begin
            Select  = sel_reg(rx);
            Ain     = 1'b1;
            state_d = T2;
          end
          op_undef: begin
            Done    = 1'b1;
            state_d = T0;
          end
          default: state_d = T0;
        endcase
      end
      T2: begin
        Select  = sel_reg(ry);
        Gin     = 1'b1;
        AddSub  = ir_q[6];
        state_d = T3;
      end
      T3: begin
        Select  = SEL_G;
        Rin     = rin_reg(rx);
        Done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed-vector bench for bus_control_unit.
// Outputs packed as {Select,Rin,Ain,Gin,IRin,AddSub,Done}.
module tb_bus_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic [9:0]  Select;
  logic [7:0]  Rin;
  logic        Ain, Gin, IRin, AddSub, Done;

  int checks = 0;
  int errors = 0;

  bus_control_unit dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .Select (Select),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .IRin   (IRin),
    .AddSub (AddSub),
    .Done   (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [22:0] ex(
    input logic [9:0] s,
    input logic [7:0] r,
    input logic       a,
    input logic       g,
    input logic       ir,
    input logic       as,
    input logic       d
  );
    return {s, r, a, g, ir, as, d};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [22:0] got,
    input logic [22:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-low-phase, check, then advance one clock
  task automatic cyc(
    input string       tag,
    input logic        run,
    input logic [15:0] din,
    input logic [22:0] exp
  );
    Run = run;
    DIN = din;
    #1;
    chk(tag, {Select, Rin, Ain, Gin, IRin, AddSub, Done}, exp);
    @(negedge Clock);
  endtask

  localparam logic [22:0] IDLE  = 23'h0;
  localparam logic [22:0] FETCH = 23'h4;

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    DIN   = '0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    cyc("idle0", 1'b0, 16'h0000, IDLE);
    cyc("idle1", 1'b0, 16'hFFFF, IDLE);
    cyc("idle2", 1'b0, 16'h0000, IDLE);

    cyc("mvi_t0", 1'b1, 16'h0048, FETCH);
    cyc("mvi_t1", 1'b0, 16'h1234,
        ex(10'h200, 8'h02, 0, 0, 0, 0, 1));
    cyc("mvi_end", 1'b0, 16'h0000, IDLE);

    cyc("mv52_t0", 1'b1, 16'h002A, FETCH);
    cyc("mv52_t1", 1'b1, 16'h0000,
        ex(10'h020, 8'h20, 0, 0, 0, 0, 1));

    cyc("mv33_t0", 1'b1, 16'h001B, FETCH);
    cyc("mv33_t1", 1'b0, 16'h0000,
        ex(10'h010, 8'h08, 0, 0, 0, 0, 1));

    cyc("sub_t0", 1'b1, 16'h00C7, FETCH);
    cyc("sub_t1", 1'b0, 16'h0000,
        ex(10'h080, 8'h00, 1, 0, 0, 0, 0));
    cyc("sub_t2", 1'b1, 16'h0000,
        ex(10'h001, 8'h00, 0, 1, 0, 1, 0));
    cyc("sub_t3", 1'b0, 16'h0000,
        ex(10'h100, 8'h01, 0, 0, 0, 0, 1));
    cyc("sub_end", 1'b0, 16'h0000, IDLE);

    cyc("add_t0", 1'b1, 16'h0087, FETCH);
    cyc("add_t1", 1'b0, 16'h0000,
        ex(10'h080, 8'h00, 1, 0, 0, 0, 0));
    cyc("add_t2", 1'b0, 16'h0000,
        ex(10'h001, 8'h00, 0, 1, 0, 0, 0));
    cyc("add_t3", 1'b0, 16'h0000,
        ex(10'h100, 8'h01, 0, 0, 0, 0, 1));

    cyc("rst_t0", 1'b1, 16'h0087, FETCH);
    cyc("rst_t1", 1'b0, 16'h0000,
        ex(10'h080, 8'h00, 1, 0, 0, 0, 0));
    Reset = 1'b1;
    cyc("rst_t2", 1'b0, 16'h0000,
        ex(10'h001, 8'h00, 0, 1, 0, 0, 0));
    Reset = 1'b0;
    cyc("rst_after", 1'b0, 16'h0000, IDLE);
    cyc("rst_no_t3", 1'b0, 16'h0000, IDLE);

    cyc("b2b_c1", 1'b1, 16'h002A, FETCH);
    cyc("b2b_c2", 1'b1, 16'h0000,
        ex(10'h020, 8'h20, 0, 0, 0, 0, 1));
    cyc("b2b_c3", 1'b1, 16'h01C0, FETCH);
    cyc("b2b_c4", 1'b1, 16'h0000,
        ex(10'h000, 8'h00, 0, 0, 0, 0, 1));
    cyc("b2b_c5", 1'b1, 16'h0048, FETCH);
    cyc("b2b_c6", 1'b1, 16'h5555,
        ex(10'h200, 8'h02, 0, 0, 0, 0, 1));
    cyc("b2b_end", 1'b0, 16'h0000, IDLE);
    cyc("b2b_idle", 1'b0, 16'h0000, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
